// File: rtl/seq_mult_pkg.sv
// Shared definitions for the multiplier arbiter and the multiplier controller bench.
package seq_mult_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);

  // Scan from farthest to nearest offset so the lowest offset from ptr wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int unsigned c;
      c = (32'(ptr) + 32'(k)) % NUM_REQ;
      if (req[IDXW'(c)]) begin
        idx = IDXW'(c);
        any = 1'b1;
      end
    end
    if (any) begin
      pick = NUM_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/seq_mult_arbiter.sv
// Shares one sequential multiplier between NUM_REQ clients with round-robin
// arbitration, a per-operation timeout and registered Moore outputs.
module seq_mult_arbiter
  import seq_mult_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [2*WIDTH-1:0]       product,
  output logic                     busy,
  output logic                     mult_go,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic                     mult_done,
  input  logic [2*WIDTH-1:0]       mult_p
);

  localparam int unsigned IDXW = $clog2(NUM_REQ);
  localparam int unsigned TW   = $clog2(TIMEOUT);
  localparam int unsigned PW   = 2 * WIDTH;

  state_t               r_state, w_state;
  logic [IDXW-1:0]      r_ptr, w_ptr;
  logic [IDXW-1:0]      r_idx, w_idx;
  logic [NUM_REQ-1:0]   r_sel, w_sel;
  logic [WIDTH-1:0]     r_a, w_a;
  logic [WIDTH-1:0]     r_b, w_b;
  logic [PW-1:0]        r_result, w_result;
  logic                 r_flag, w_flag;
  logic [TW-1:0]        r_timer, w_timer;

  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic [NUM_REQ-1:0]   r_done, w_done;
  logic                 r_err, w_err;
  logic [PW-1:0]        r_product, w_product;
  logic                 r_busy, w_busy;
  logic                 r_go, w_go;

  logic [NUM_REQ-1:0]   w_arb_pick;
  logic [IDXW-1:0]      w_arb_idx;
  logic                 w_arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_arb_pick),
    .idx  (w_arb_idx),
    .any  (w_arb_any)
  );

  // Next-state, datapath and output decode; outputs follow the next state.
  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_idx     = r_idx;
    w_sel     = r_sel;
    w_a       = r_a;
    w_b       = r_b;
    w_result  = r_result;
    w_flag    = r_flag;
    w_timer   = r_timer;
    w_gnt     = '0;
    w_done    = '0;
    w_err     = 1'b0;
    w_product = '0;
    w_busy    = 1'b0;
    w_go      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_arb_any) begin
          w_idx = w_arb_idx;
          w_sel = w_arb_pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_pick[i]) begin
              w_a = a_in[i*WIDTH +: WIDTH];
              w_b = b_in[i*WIDTH +: WIDTH];
            end
          end
          w_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_timer = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        w_timer = r_timer + TW'(1);
        // A completion on the timeout cycle still counts as success.
        if (mult_done) begin
          w_result = mult_p;
          w_flag   = 1'b0;
          w_state  = S_RESP;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_result = '0;
          w_flag   = 1'b1;
          w_state  = S_RESP;
        end
      end
      S_RESP: begin
        w_ptr   = (r_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_idx + IDXW'(1);
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    case (w_state)
      S_LAUNCH: begin
        w_go   = 1'b1;
        w_gnt  = w_sel;
        w_busy = 1'b1;
      end
      S_WAIT: begin
        w_gnt  = w_sel;
        w_busy = 1'b1;
      end
      S_RESP: begin
        w_gnt     = w_sel;
        w_busy    = 1'b1;
        w_done    = w_sel;
        w_product = w_result;
        w_err     = w_flag;
      end
      default: ;
    endcase

    // The error flag lives only for the response cycle.
    if (r_state == S_RESP) begin
      w_flag = 1'b0;
    end
  end

  // State, datapath and output registers; reset aborts without a response.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_sel     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_flag    <= 1'b0;
      r_timer   <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_go      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_idx     <= w_idx;
      r_sel     <= w_sel;
      r_a       <= w_a;
      r_b       <= w_b;
      r_result  <= w_result;
      r_flag    <= w_flag;
      r_timer   <= w_timer;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_err     <= w_err;
      r_product <= w_product;
      r_busy    <= w_busy;
      r_go      <= w_go;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign product = r_product;
  assign busy    = r_busy;
  assign mult_go = r_go;
  assign mult_a  = r_a;
  assign mult_b  = r_b;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Directed bench for seq_mult_arbiter with a behavioural multiplier model.
module tb_seq_mult_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;

  logic            clk;
  logic            clr_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] a_in;
  logic [NR*W-1:0] b_in;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic            err;
  logic [2*W-1:0]  product;
  logic            busy;
  logic            mult_go;
  logic [W-1:0]    mult_a;
  logic [W-1:0]    mult_b;
  logic            mult_done;
  logic [2*W-1:0]  mult_p;

  int n_checks = 0;
  int n_errors = 0;

  int model_n     = 5;
  bit model_never = 1'b0;
  int model_cnt;
  int go_cnt;

  seq_mult_arbiter #(
    .NUM_REQ (NR),
    .WIDTH   (W),
    .TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .product   (product),
    .busy      (busy),
    .mult_go   (mult_go),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_done (mult_done),
    .mult_p    (mult_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: mult_done pulses model_n cycles after the go cycle.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      model_cnt <= 0;
      mult_done <= 1'b0;
      mult_p    <= '0;
    end else begin
      mult_done <= 1'b0;
      if (mult_go) begin
        mult_p    <= 16'(mult_a) * 16'(mult_b);
        model_cnt <= model_never ? 0 : model_n - 1;
      end else if (model_cnt > 0) begin
        if (model_cnt == 1) mult_done <= 1'b1;
        model_cnt <= model_cnt - 1;
      end
    end
  end

  // Count start pulses seen by the multiplier.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) go_cnt <= 0;
    else if (mult_go) go_cnt <= go_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int c, input logic [7:0] a, input logic [7:0] b);
    a_in[c*W +: W] = a;
    b_in[c*W +: W] = b;
  endtask

  // Wait (bounded) for the mult_go cycle; returns with the bench at that negedge.
  task automatic wait_go(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mult_go) return;
    end
    check({tag, "_go_timeout"}, 32'd0, 32'd1);
  endtask

  // Count cycles from the go cycle to the done cycle and capture the response.
  task automatic wait_done(input string tag, output int cyc, output logic [NR-1:0] d,
                           output logic e, output logic [2*W-1:0] p);
    cyc = -1; d = '0; e = 1'b0; p = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done != '0) begin
        cyc = i; d = done; e = err; p = product;
        return;
      end
    end
    check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  int             cyc;
  logic [NR-1:0]  d;
  logic           e;
  logic [2*W-1:0] p;
  int             go0;
  int             seen;

  initial begin
    clr_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_go", 32'(mult_go), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_mult_a", 32'(mult_a), 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // 1: single client, 13*11
    model_n = 20;
    set_ops(0, 8'd13, 8'd11);
    go0 = go_cnt;
    req = 4'b0001;
    wait_go("t1");
    req = '0;
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_mult_a", 32'(mult_a), 32'd13);
    check("t1_mult_b", 32'(mult_b), 32'd11);
    wait_done("t1", cyc, d, e, p);
    check("t1_lat", 32'(cyc), 32'd21);
    check("t1_done", 32'(d), 32'b0001);
    check("t1_err", 32'(e), 32'd0);
    check("t1_prod", 32'(p), 32'd143);
    @(negedge clk);
    check("t1_done_once", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_go_cnt", 32'(go_cnt - go0), 32'd1);

    // 2: contention from ptr=0, products (k+2)*(k+3)
    do_reset();
    model_n = 5;
    for (int k = 0; k < 4; k++) set_ops(k, 8'(k + 2), 8'(k + 3));
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_go("t2");
      if (r == 4) req = '0;
      check("t2_gnt", 32'(gnt), 32'(1 << (r % 4)));
      wait_done("t2", cyc, d, e, p);
      check("t2_done", 32'(d), 32'(1 << (r % 4)));
      check("t2_prod", 32'(p), 32'(((r % 4) + 2) * ((r % 4) + 3)));
    end
    @(negedge clk);

    // 3: move ptr to 3 via client 2, then req=0101 wraps to 0 then 2
    set_ops(2, 8'd9, 8'd9);
    req = 4'b0100;
    wait_go("t3a");
    req = '0;
    wait_done("t3a", cyc, d, e, p);
    check("t3a_prod", 32'(p), 32'd81);
    set_ops(0, 8'd10, 8'd10);
    req = 4'b0101;
    wait_go("t3b");
    check("t3_first", 32'(gnt), 32'b0001);
    wait_done("t3b", cyc, d, e, p);
    check("t3_first_prod", 32'(p), 32'd100);
    wait_go("t3c");
    req = '0;
    check("t3_second", 32'(gnt), 32'b0100);
    wait_done("t3c", cyc, d, e, p);
    check("t3_second_prod", 32'(p), 32'd81);
    @(negedge clk);

    // 4: timeout, then normal service
    model_never = 1'b1;
    set_ops(1, 8'd7, 8'd9);
    req = 4'b0010;
    wait_go("t4");
    req = '0;
    wait_done("t4", cyc, d, e, p);
    check("t4_lat", 32'(cyc), 32'd65);
    check("t4_done", 32'(d), 32'b0010);
    check("t4_err", 32'(e), 32'd1);
    check("t4_prod", 32'(p), 32'd0);
    @(negedge clk);
    check("t4_err_once", 32'(err), 32'd0);
    model_never = 1'b0;
    req = 4'b0010;
    wait_go("t4b");
    req = '0;
    wait_done("t4b", cyc, d, e, p);
    check("t4b_err", 32'(e), 32'd0);
    check("t4b_prod", 32'(p), 32'd63);
    @(negedge clk);

    // 6a: mult_done lands on the timeout cycle
    model_n = 64;
    set_ops(3, 8'd200, 8'd100);
    req = 4'b1000;
    wait_go("t6a");
    req = '0;
    wait_done("t6a", cyc, d, e, p);
    check("t6a_lat", 32'(cyc), 32'd65);
    check("t6a_err", 32'(e), 32'd0);
    check("t6a_prod", 32'(p), 32'd20000);
    @(negedge clk);

    // 6b: operands changed and req dropped after grant
    model_n = 8;
    set_ops(0, 8'd12, 8'd10);
    req = 4'b0001;
    wait_go("t6b");
    req = '0;
    set_ops(0, 8'd99, 8'd99);
    wait_done("t6b", cyc, d, e, p);
    check("t6b_done", 32'(d), 32'b0001);
    check("t6b_prod", 32'(p), 32'd120);
    check("t6b_mult_a", 32'(mult_a), 32'd12);
    @(negedge clk);

    // 5: reset in WAIT aborts silently
    model_n = 30;
    set_ops(1, 8'd3, 8'd4);
    req = 4'b0010;
    wait_go("t5");
    req = '0;
    repeat (5) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("t5_abort_gnt", 32'(gnt), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_mult_a", 32'(mult_a), 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done != '0 || err) seen++;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    model_n = 6;
    set_ops(1, 8'd255, 8'd255);
    set_ops(0, 8'd255, 8'd255);
    req = 4'b0011;
    wait_go("t5b");
    req = '0;
    check("t5b_gnt", 32'(gnt), 32'b0001);
    wait_done("t5b", cyc, d, e, p);
    check("t5b_err", 32'(e), 32'd0);
    check("t5b_prod", 32'(p), 32'd65025);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
